// File: rtl/serial_adder_ctrl.sv
// Controller for a bit-serial adder around an external one-bit full-adder cell.
// Shifts the operands LSB-first into the cell and collects its sum and carry.
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_c,
  input  logic             fa_s,
  input  logic             fa_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] a_sh, b_sh, sum_sh;
  logic             carry_q;
  logic [CW-1:0]    cnt;
  logic             accept;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    fa_a      = 1'b0;
    fa_b      = 1'b0;
    fa_c      = 1'b0;
    sum       = '0;
    carry_out = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        in_ready = ~rst;
        accept   = in_valid & ~rst;
        if (accept) state_nx = RUN;
      end
      RUN: begin
        fa_a = a_sh[0];
        fa_b = b_sh[0];
        fa_c = carry_q;
        if (cnt == CNT_LAST) state_nx = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        sum       = sum_sh;
        carry_out = carry_q;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // sum_sh is deliberately not cleared on accept; every bit is overwritten during RUN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh    <= '0;
      b_sh    <= '0;
      sum_sh  <= '0;
      carry_q <= 1'b0;
      cnt     <= '0;
    end else if (accept) begin
      a_sh    <= op_a;
      b_sh    <= op_b;
      carry_q <= cin;
      cnt     <= '0;
    end else if (state == RUN) begin
      sum_sh  <= {fa_s, sum_sh[WIDTH-1:1]};
      carry_q <= fa_cout;
      a_sh    <= {1'b0, a_sh[WIDTH-1:1]};
      b_sh    <= {1'b0, b_sh[WIDTH-1:1]};
      cnt     <= cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Bench for serial_adder_ctrl: full-adder cell modelled on the fa_* ports,
// results checked against plain integer addition.
module tb_serial_adder_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  int         total = 0;
  int         bad = 0;
  int         cyc = 0;

  // WIDTH = 8 instance
  logic       in_valid, in_ready, cin, fa_a, fa_b, fa_c, fa_s, fa_cout;
  logic       out_valid, out_ready, carry_out;
  logic [7:0] op_a, op_b, sum;

  // WIDTH = 2 instance
  logic       in_valid2, in_ready2, cin2, fa_a2, fa_b2, fa_c2, fa_s2, fa_cout2;
  logic       out_valid2, out_ready2, carry_out2;
  logic [1:0] op_a2, op_b2, sum2;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign fa_s     = fa_a ^ fa_b ^ fa_c;
  assign fa_cout  = (fa_a & fa_b) | (fa_c & (fa_a ^ fa_b));
  assign fa_s2    = fa_a2 ^ fa_b2 ^ fa_c2;
  assign fa_cout2 = (fa_a2 & fa_b2) | (fa_c2 & (fa_a2 ^ fa_b2));

  serial_adder_ctrl #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .cin(cin),
    .fa_a(fa_a), .fa_b(fa_b), .fa_c(fa_c), .fa_s(fa_s), .fa_cout(fa_cout),
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .carry_out(carry_out)
  );

  serial_adder_ctrl #(.WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
    .op_a(op_a2), .op_b(op_b2), .cin(cin2),
    .fa_a(fa_a2), .fa_b(fa_b2), .fa_c(fa_c2), .fa_s(fa_s2), .fa_cout(fa_cout2),
    .out_valid(out_valid2), .out_ready(out_ready2), .sum(sum2), .carry_out(carry_out2)
  );

  // One complete operation on the WIDTH=8 instance; result held for 'hold'
  // cycles, optionally with a competing in_valid during the hold.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic c,
                        input int hold, input bit poke);
    logic [8:0] expv;
    logic [7:0] a_seq, b_seq;
    logic       c0;
    logic       early;
    int         n;
    expv = {1'b0, a} + {1'b0, b} + {8'd0, c};
    op_a = a; op_b = b; cin = c; in_valid = 1'b1; out_ready = 1'b0;
    n = 0;
    while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
    total++;
    if (in_ready !== 1'b1) begin
      bad++; $display("FAIL op_in_ready got=%b want=1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    op_a = 8'($urandom); op_b = 8'($urandom); cin = 1'($urandom);
    a_seq[0] = fa_a; b_seq[0] = fa_b; c0 = fa_c;
    early = out_valid | in_ready;
    for (int i = 1; i < 8; i++) begin
      @(posedge clk); #1;
      a_seq[i] = fa_a; b_seq[i] = fa_b;
      early = early | out_valid | in_ready;
    end
    total++;
    if (early !== 1'b0) begin
      bad++; $display("FAIL op_busy_flags got=%b want=0", early);
    end
    @(posedge clk); #1;
    total++;
    if (out_valid !== 1'b1) begin
      bad++; $display("FAIL op_latency out_valid got=%b want=1", out_valid);
    end
    total++;
    if ({carry_out, sum} !== expv) begin
      bad++; $display("FAIL op_result %h+%h+%b got=%h want=%h", a, b, c, {carry_out, sum}, expv);
    end
    total++;
    if ({a_seq, b_seq, c0} !== {a, b, c}) begin
      bad++; $display("FAIL op_fa_seq got=%h want=%h", {a_seq, b_seq, c0}, {a, b, c});
    end
    if (poke) begin
      op_a = 8'h11; op_b = 8'h22; in_valid = 1'b1;
    end
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      total++;
      if ({out_valid, in_ready, carry_out, sum} !== {2'b10, expv}) begin
        bad++; $display("FAIL op_hold cyc%0d got=%h want=%h", i, {out_valid, in_ready, carry_out, sum}, {2'b10, expv});
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    total++;
    if ({out_valid, in_ready, carry_out, sum} !== {2'b01, 9'd0}) begin
      bad++; $display("FAIL op_release got=%h want=%h", {out_valid, in_ready, carry_out, sum}, {2'b01, 9'd0});
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b1; out_ready = 1'b1; op_a = 8'hFF; op_b = 8'hFF; cin = 1'b1;
    in_valid2 = 1'b0; out_ready2 = 1'b0; op_a2 = '0; op_b2 = '0; cin2 = 1'b0;
    #1;
    total++;
    if ({in_ready, out_valid, fa_a, fa_b, fa_c, carry_out, sum} !== 14'd0) begin
      bad++; $display("FAIL reset_outputs got=%h want=0", {in_ready, out_valid, fa_a, fa_b, fa_c, carry_out, sum});
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
    rst = 1'b0;
    #1;
    total++;
    if ({in_ready, out_valid} !== 2'b10) begin
      bad++; $display("FAIL reset_release got=%b want=10", {in_ready, out_valid});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    run_op(8'h5A, 8'h3C, 1'b0, 0, 1'b0);
    run_op(8'hFF, 8'h01, 1'b0, 0, 1'b0);
    run_op(8'h00, 8'h00, 1'b1, 0, 1'b0);
  endtask

  task automatic test_backpressure();
    run_op(8'hC3, 8'h5D, 1'b1, 5, 1'b1);
    // the ignored in_valid must not have started an operation
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({in_ready, out_valid} !== 2'b10) begin
      bad++; $display("FAIL bp_no_accept got=%b want=10", {in_ready, out_valid});
    end
  endtask

  task automatic test_reset_mid_run();
    bit seen;
    op_a = 8'hAA; op_b = 8'h55; cin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (in_ready !== 1'b0) begin
      bad++; $display("FAIL rr_running in_ready got=%b want=0", in_ready);
    end
    #1 rst = 1'b1;
    #1;
    total++;
    if ({in_ready, out_valid, fa_a, fa_b, fa_c, carry_out, sum} !== 14'd0) begin
      bad++; $display("FAIL rr_outputs got=%h want=0", {in_ready, out_valid, fa_a, fa_b, fa_c, carry_out, sum});
    end
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (12) begin @(posedge clk); #1; seen = seen | out_valid; end
    total++;
    if (seen !== 1'b0) begin
      bad++; $display("FAIL rr_no_result out_valid got=%b want=0", seen);
    end
    run_op(8'h01, 8'h02, 1'b0, 0, 1'b0);
  endtask

  task automatic test_random();
    for (int k = 0; k < 20; k++)
      run_op(8'($urandom), 8'($urandom), 1'($urandom), int'($urandom_range(0, 3)), 1'($urandom));
  endtask

  task automatic test_back_to_back();
    logic [7:0] as [3] = '{8'h80, 8'h7F, 8'h12};
    logic [7:0] bs [3] = '{8'h80, 8'h01, 8'h34};
    int         t [3];
    int         n;
    logic [8:0] expv;
    op_a = as[0]; op_b = bs[0]; cin = 1'b0;
    in_valid = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      n = 0;
      do begin @(posedge clk); #1; n++; end while (!out_valid && n < 40);
      t[k] = cyc;
      expv = {1'b0, as[k]} + {1'b0, bs[k]};
      total++;
      if (out_valid !== 1'b1 || {carry_out, sum} !== expv) begin
        bad++; $display("FAIL b2b_result%0d v=%b got=%h want=%h", k, out_valid, {carry_out, sum}, expv);
      end
      if (k < 2) begin op_a = as[k+1]; op_b = bs[k+1]; end
      else in_valid = 1'b0;
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
    total++;
    if (t[1] - t[0] !== 10 || t[2] - t[1] !== 10) begin
      bad++; $display("FAIL b2b_spacing got=%0d,%0d want=10,10", t[1] - t[0], t[2] - t[1]);
    end
  endtask

  task automatic test_width2();
    int n;
    op_a2 = 2'd3; op_b2 = 2'd3; cin2 = 1'b1; in_valid2 = 1'b1; out_ready2 = 1'b0;
    @(posedge clk); #1;
    in_valid2 = 1'b0;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!out_valid2 && n < 20);
    total++;
    if (n !== 2 || {carry_out2, sum2} !== 3'b111) begin
      bad++; $display("FAIL w2_result lat=%0d got=%b want lat=2 %b", n, {carry_out2, sum2}, 3'b111);
    end
    out_ready2 = 1'b1;
    @(posedge clk); #1;
    out_ready2 = 1'b0;
    total++;
    if ({in_ready2, out_valid2, sum2} !== 4'b1000) begin
      bad++; $display("FAIL w2_release got=%b want=1000", {in_ready2, out_valid2, sum2});
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid_run();
    test_random();
    test_back_to_back();
    test_width2();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
